// File: rtl/vma_div_pkg.sv
// Shared types and helpers for the vector-lane divider (div_rem).
// The optional signed mode is selected with the VMA_DIV_SIGNED_EN macro.
package vma_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width of the iteration counter that walks the vdw_p quotient bits.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_rem_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when the partial remainder is large enough.
module div_rem_step #(
    parameter int vdw_p = 32
) (
    input  logic [vdw_p:0]   rem,
    input  logic             dvd_msb,
    input  logic [vdw_p-1:0] divisor,
    output logic [vdw_p:0]   next_rem,
    output logic             q_bit
);

    logic [vdw_p:0] shifted_s;
    logic [vdw_p:0] divisor_ext_s;
    logic [vdw_p:0] diff_s;

    // Trial subtraction runs one bit wider than the operands so it cannot overflow.
    always_comb begin
        shifted_s     = (rem << 1'b1) | {{vdw_p{1'b0}}, dvd_msb};
        divisor_ext_s = {1'b0, divisor};
        diff_s        = shifted_s - divisor_ext_s;
        if (shifted_s >= divisor_ext_s) begin
            next_rem = diff_s;
            q_bit    = 1'b1;
        end else begin
            next_rem = shifted_s;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_rem.sv
// Iterative radix-2 restoring divider with valid/ready operand and valid/yumi result handshakes.
// Define VMA_DIV_SIGNED_EN to add the signed_i port and two's-complement division.
module div_rem
    import vma_div_pkg::*;
#(
    parameter int vdw_p = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [vdw_p-1:0] dividend_i,
    input  logic [vdw_p-1:0] divisor_i,
`ifdef VMA_DIV_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic             v_o,
    input  logic             yumi_i,
    output logic [vdw_p-1:0] quotient_o,
    output logic [vdw_p-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int                     cnt_w_c    = cnt_width(vdw_p);
    localparam logic [cnt_w_c-1:0]     cnt_last_c = cnt_w_c'(vdw_p - 1);
    localparam logic [cnt_w_c-1:0]     cnt_one_c  = cnt_w_c'(1'b1);
    localparam logic [vdw_p-1:0]       one_c      = vdw_p'(1'b1);

    div_state_e          state_r;
    logic [cnt_w_c-1:0]  cnt_r;
    logic [vdw_p:0]      rem_r;
    logic [vdw_p-1:0]    dvq_r;
    logic [vdw_p-1:0]    divisor_r;
    logic                neg_q_r;
    logic                neg_r_r;

    logic                op_signed_s;
    logic                dvd_neg_s;
    logic                dsr_neg_s;
    logic [vdw_p-1:0]    abs_dvd_s;
    logic [vdw_p-1:0]    abs_dsr_s;
    logic [vdw_p:0]      step_rem_s;
    logic                step_q_s;
    logic [vdw_p-1:0]    q_raw_s;
    logic [vdw_p-1:0]    q_fix_s;
    logic [vdw_p-1:0]    r_fix_s;

    // Operand magnitudes and signs captured at accept time.
    always_comb begin
`ifdef VMA_DIV_SIGNED_EN
        op_signed_s = signed_i;
`else
        op_signed_s = 1'b0;
`endif
        dvd_neg_s = op_signed_s & dividend_i[vdw_p-1];
        dsr_neg_s = op_signed_s & divisor_i[vdw_p-1];
        if (dvd_neg_s) begin
            abs_dvd_s = ~dividend_i + one_c;
        end else begin
            abs_dvd_s = dividend_i;
        end
        if (dsr_neg_s) begin
            abs_dsr_s = ~divisor_i + one_c;
        end else begin
            abs_dsr_s = divisor_i;
        end
    end

    div_rem_step #(
        .vdw_p(vdw_p)
    ) u_step (
        .rem     (rem_r),
        .dvd_msb (dvq_r[vdw_p-1]),
        .divisor (divisor_r),
        .next_rem(step_rem_s),
        .q_bit   (step_q_s)
    );

    // Sign fixup of the final iteration; the most-negative / -1 case falls out unchanged.
    always_comb begin
        q_raw_s = {dvq_r[vdw_p-2:0], step_q_s};
        if (neg_q_r) begin
            q_fix_s = ~q_raw_s + one_c;
        end else begin
            q_fix_s = q_raw_s;
        end
        if (neg_r_r) begin
            r_fix_s = ~step_rem_s[vdw_p-1:0] + one_c;
        end else begin
            r_fix_s = step_rem_s[vdw_p-1:0];
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            cnt_r       <= {cnt_w_c{1'b0}};
            rem_r       <= {(vdw_p + 1){1'b0}};
            dvq_r       <= {vdw_p{1'b0}};
            divisor_r   <= {vdw_p{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ready_o     <= 1'b1;
            v_o         <= 1'b0;
            quotient_o  <= {vdw_p{1'b0}};
            remainder_o <= {vdw_p{1'b0}};
            div_zero_o  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (v_i && ready_o) begin
                        ready_o <= 1'b0;
                        if (divisor_i == {vdw_p{1'b0}}) begin
                            quotient_o  <= {vdw_p{1'b1}};
                            remainder_o <= dividend_i;
                            div_zero_o  <= 1'b1;
                            v_o         <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            dvq_r     <= abs_dvd_s;
                            divisor_r <= abs_dsr_s;
                            rem_r     <= {(vdw_p + 1){1'b0}};
                            neg_q_r   <= dvd_neg_s ^ dsr_neg_s;
                            neg_r_r   <= dvd_neg_s;
                            cnt_r     <= {cnt_w_c{1'b0}};
                            state_r   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Dividend bits shift out the top while quotient bits shift in at the bottom.
                    rem_r <= step_rem_s;
                    dvq_r <= q_raw_s;
                    if (cnt_r == cnt_last_c) begin
                        cnt_r       <= {cnt_w_c{1'b0}};
                        quotient_o  <= q_fix_s;
                        remainder_o <= r_fix_s;
                        div_zero_o  <= 1'b0;
                        v_o         <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + cnt_one_c;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_o     <= 1'b0;
                        ready_o <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {cnt_w_c{1'b0}};
                    ready_o <= 1'b1;
                    v_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_rem.sv
// Self-checking bench for div_rem: arithmetic reference model plus directed vectors.
// Signed vectors run only when VMA_DIV_SIGNED_EN is defined.
module tb_div_rem;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         signed_i;
    logic         v_o;
    logic         yumi_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_zero_o;

    div_rem #(.vdw_p(W)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
`ifdef VMA_DIV_SIGNED_EN
        .signed_i   (signed_i),
`endif
        .v_o        (v_o),
        .yumi_i     (yumi_i),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic [W-1:0] min_neg;
        logic [W-1:0] minus_one;
        min_neg   = {1'b1, {(W-1){1'b0}}};
        minus_one = {W{1'b1}};
        dz = 1'b0;
        if (b == {W{1'b0}}) begin
            q  = {W{1'b1}};
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            if (a == min_neg && b == minus_one) begin
                q = a;
                r = {W{1'b0}};
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         ent;
    bit           exp_ready = 1'b1;
    bit           exp_vo;
    logic [W-1:0] mq, mr;
    logic         mdz;

    // Scoreboard: predicts ready_o, v_o and result fields every cycle.
    always @(negedge clk) begin
        if (!reset_n_i) begin
            sb.delete();
            exp_ready = 1'b1;
            chk("rst_ready", ready_o, 64'd1);
            chk("rst_v_o", v_o, 64'd0);
            chk("rst_q", quotient_o, 64'd0);
            chk("rst_r", remainder_o, 64'd0);
            chk("rst_dz", div_zero_o, 64'd0);
        end else begin
            exp_vo = (sb.size() > 0) && (cyc >= sb[0].due);
            chk("ready_o", ready_o, exp_ready);
            chk("v_o", v_o, exp_vo);
            if (exp_vo && v_o) begin
                chk("quotient", quotient_o, sb[0].q);
                chk("remainder", remainder_o, sb[0].r);
                chk("div_zero", div_zero_o, sb[0].dz);
            end
            if (exp_vo && yumi_i) begin
                void'(sb.pop_front());
                exp_ready = 1'b1;
            end else if (v_i && exp_ready) begin
                model(dividend_i, divisor_i, signed_i, mq, mr, mdz);
                ent.q   = mq;
                ent.r   = mr;
                ent.dz  = mdz;
                ent.due = cyc + (mdz ? 1 : W + 1);
                sb.push_back(ent);
                exp_ready = 1'b0;
            end
        end
    end

    // Presents one operand pair; returns the edge count just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int acc);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("send_ready", ready_o, 64'd1);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        v_i        = 1'b1;
        @(posedge clk);
        #2;
        acc        = cyc;
        v_i        = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'b0;
    endtask

    // Waits (bounded) for v_o; returns at a negedge with v_o high.
    task automatic wait_vo(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!v_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        chk("v_o_timeout", v_o, 64'd1);
    endtask

    task automatic realign();
        @(posedge clk);
        #2;
    endtask

    int acc, at, ycyc;

    initial begin
        reset_n_i  = 1'b0;
        v_i        = 1'b0;
        yumi_i     = 1'b0;
        dividend_i = {W{1'b0}};
        divisor_i  = {W{1'b0}};
        signed_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_ready", ready_o, 64'd1);
        chk("init_v_o", v_o, 64'd0);
        #1;
        reset_n_i = 1'b1;

        // 100/7 with yumi held: 33 edges counting the accept edge
        yumi_i = 1'b1;
        send(32'd100, 32'd7, 1'b0, acc);
        wait_vo(at);
        chk("t1_latency", at - acc + 1, 64'd33);
        chk("t1_q", quotient_o, 64'd14);
        chk("t1_r", remainder_o, 64'd2);
        chk("t1_dz", div_zero_o, 64'd0);
        realign();

        send(32'hFFFF_FFFF, 32'd1, 1'b0, acc);
        wait_vo(at);
        chk("t2a_q", quotient_o, 64'hFFFF_FFFF);
        chk("t2a_r", remainder_o, 64'd0);
        realign();
        chk("t2_throughput_ready", ready_o, 64'd1);
        ycyc = acc;
        send(32'd5, 32'd9, 1'b0, acc);
        chk("t2_throughput", acc - ycyc, 64'd34);
        wait_vo(at);
        chk("t2b_q", quotient_o, 64'd0);
        chk("t2b_r", remainder_o, 64'd5);
        realign();

        // divide by zero
        send(32'h0000_1234, 32'd0, 1'b0, acc);
        wait_vo(at);
        chk("t3_latency", at - acc + 1, 64'd1);
        chk("t3_q", quotient_o, 64'hFFFF_FFFF);
        chk("t3_r", remainder_o, 64'h1234);
        chk("t3_dz", div_zero_o, 64'd1);
        realign();

        // result held for 10 cycles while v_i is ignored
        yumi_i = 1'b0;
        send(32'd1000, 32'd10, 1'b0, acc);
        wait_vo(at);
        for (int i = 0; i < 10; i++) begin
            realign();
            v_i        = 1'b1;
            dividend_i = $urandom;
            divisor_i  = $urandom | 32'd1;
            chk("t4_hold_ready", ready_o, 64'd0);
            chk("t4_hold_v_o", v_o, 64'd1);
            chk("t4_hold_q", quotient_o, 64'd100);
            chk("t4_hold_r", remainder_o, 64'd0);
        end
        realign();
        v_i    = 1'b0;
        yumi_i = 1'b1;
        realign();
        ycyc   = cyc;
        yumi_i = 1'b0;
        chk("t4_ready_after_yumi", ready_o, 64'd1);
        send(32'd77, 32'd5, 1'b0, acc);
        chk("t4_accept_next", acc - ycyc, 64'd1);
        yumi_i = 1'b1;
        wait_vo(at);
        chk("t4b_q", quotient_o, 64'd15);
        chk("t4b_r", remainder_o, 64'd2);
        realign();

        // reset 5 cycles into BUSY
        send(32'd123456, 32'd789, 1'b0, acc);
        repeat (5) realign();
        reset_n_i = 1'b0;
        #1;
        chk("t5_v_o", v_o, 64'd0);
        chk("t5_ready", ready_o, 64'd1);
        chk("t5_q", quotient_o, 64'd0);
        chk("t5_r", remainder_o, 64'd0);
        #1;
        repeat (2) realign();
        reset_n_i = 1'b1;
        send(32'd50000, 32'd3, 1'b0, acc);
        wait_vo(at);
        chk("t5b_q", quotient_o, 64'd16666);
        chk("t5b_r", remainder_o, 64'd2);
        realign();

`ifdef VMA_DIV_SIGNED_EN
        send(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
        wait_vo(at);
        chk("t6a_q", quotient_o, 64'hFFFF_FFFD);
        chk("t6a_r", remainder_o, 64'hFFFF_FFFF);
        realign();
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
        wait_vo(at);
        chk("t6b_latency", at - acc + 1, 64'd33);
        chk("t6b_q", quotient_o, 64'h8000_0000);
        chk("t6b_r", remainder_o, 64'd0);
        chk("t6b_dz", div_zero_o, 64'd0);
        realign();
        send(32'd7, 32'hFFFF_FFFE, 1'b1, acc);
        wait_vo(at);
        chk("t6c_q", quotient_o, 64'hFFFF_FFFD);
        chk("t6c_r", remainder_o, 64'd1);
        realign();
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
        wait_vo(at);
        chk("t6d_q", quotient_o, 64'd0);
        chk("t6d_r", remainder_o, 64'h8000_0000);
        realign();
`endif

        repeat (3) realign();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
